seq_mult_taint_gen: RTL and testbench
=====================================

Name: seq_mult_taint_gen

Overview:
- Parametrised radix-2 shift-add sequential multiplier with per-bit taint tracking.
- Next generation of the team's taint-tracked multiplier.
- Adds independent operand widths, runtime signed/unsigned mode, a start/busy/done handshake, and an explicit product taint output.
- Sits in the taint-tracking test designs as the reference arithmetic unit for information-flow checks.

Parameters:
- A_WIDTH, 8, multiplicand width in bits (>=2)
- B_WIDTH, 8, multiplier width in bits (>=2); equals the number of RUN iterations
- P_WIDTH, A_WIDTH+B_WIDTH, product width (derived; do not override)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin operation; sampled in IDLE only
- signed_mode  in  1  1 = two's-complement operands; sampled with start
- multiplicand  in  A_WIDTH  operand A; sampled with start
- multiplier  in  B_WIDTH  operand B; sampled with start
- start_t  in  1  taint of start/signed_mode
- multiplicand_t  in  A_WIDTH  per-bit taint of A
- multiplier_t  in  B_WIDTH  per-bit taint of B
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, product valid
- product  out  P_WIDTH  result; held until next accepted start
- product_t  out  P_WIDTH  per-bit taint of product

Behaviour:
- Reset (rst_n low, any time, including mid-operation): state IDLE; busy=0, done=0, product=0, product_t=0; step counter=0. Deassertion is synchronised by the flop; there is no partial result.
- States:
  - IDLE: start=1 at an edge latches the operands and taints, clears the accumulator and taint accumulator, counter=0, goes to RUN. Otherwise stays.
  - RUN: one iteration per edge for bit i=counter of B, then counter+1.
    - Unsigned: acc += zero-extended A << i when B[i]=1.
    - Signed: acc += sign-extended A << i for i<B_WIDTH-1. At i=B_WIDTH-1, acc -= sign-extended A << (B_WIDTH-1) when B[MSB]=1.
    - All arithmetic is modulo 2^P_WIDTH.
    - After iteration B_WIDTH-1, go to DONE; product and product_t are loaded on that edge.
  - DONE: done=1 for exactly one cycle, busy=1; next edge goes to IDLE.
- Latency: start sampled at edge N; done high in the cycle after edge N+B_WIDTH; IDLE after edge N+B_WIDTH+1.
- start in RUN/DONE is ignored; operand changes after acceptance have no effect.
- Back-to-back: start may be asserted in the cycle after DONE (IDLE).
- Taint rule (conservative, upward-smearing because carries propagate upward). ones denotes the all-ones P_WIDTH vector. Per iteration i, OR into the taint accumulator:
  - multiplier_t[i]=1: ones << i
  - else if B[i]=1 (or signed final step) and multiplicand_t!=0: ones << (i + index of lowest set bit of multiplicand_t)
- start_t=1 forces product_t = ones.
- product_t is updated only together with product.

Optional Feature:
- Macro: SEQ_MULT_EARLY_EXIT_EN
- Defined: in RUN, unsigned mode only, if all remaining multiplier bits above i are zero and all remaining multiplier_t bits above i are zero, go to DONE after iteration i. Latency drops to (index of highest set bit of B, or highest set bit of multiplier_t, whichever is higher; 0 if both are zero) + 1 cycles. Results and taint are identical to the full run. Signed mode is always a full run.
- Undefined: fixed latency of B_WIDTH RUN cycles for all inputs.

Test Plan (defaults 8x8):
- Unsigned 255 x 255, no taint: done after edge N+8, product=16'hFE01, product_t=0, busy low after edge N+9.
- Signed -3 x 5 (A=8'hFD, B=8'h05): product=16'hFFF1. Signed -128 x -128: product=16'h4000. Unsigned 8'h80 x 8'h80: product=16'h4000.
- Taint, unsigned A=3, B=2:
  - multiplicand_t=8'h01 -> product=6, product_t=16'hFFFE.
  - multiplier_t=8'h80, multiplicand_t=0 -> product_t=16'hFF80.
  - start_t=1 -> product_t=16'hFFFF.
- Handshake, start 15 x 15:
  - Re-assert start with 1 x 2 during RUN: ignored; product=225 at done.
  - Then start 1 x 2 the cycle after DONE: product=2.
- Reset mid-RUN: start 92 x 75, drop rst_n at iteration 4 -> immediately busy=0, done=0, product=0, product_t=0. Restart 42 x 78 -> product=3276.
- Early exit, unsigned 12 x 1:
  - With SEQ_MULT_EARLY_EXIT_EN: done after edge N+1.
  - Without it: done after edge N+8.
  - Both: product=12. Signed mode: done after edge N+8 in either build.

Source files
------------

// File: rtl/seq_mult_taint_gen.sv
// Radix-2 shift-add sequential multiplier with per-bit taint, optional SEQ_MULT_EARLY_EXIT_EN.
// Latency: B_WIDTH RUN cycles then one DONE cycle; fewer with early exit in unsigned mode.
// No backpressure: start is only sampled in IDLE, ignored while busy.
module seq_mult_taint_gen #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [A_WIDTH-1:0] multiplicand,
  input  logic [B_WIDTH-1:0] multiplier,
  input  logic               start_t,
  input  logic [A_WIDTH-1:0] multiplicand_t,
  input  logic [B_WIDTH-1:0] multiplier_t,
  output logic               busy,
  output logic               done,
  output logic [P_WIDTH-1:0] product,
  output logic [P_WIDTH-1:0] product_t
);

  localparam int CW = $clog2(B_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(B_WIDTH - 1);
  localparam logic [P_WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [A_WIDTH-1:0] a_q, at_q;
  logic [B_WIDTH-1:0] b_q, bt_q;
  logic               sm_q, st_q;
  logic [CW-1:0]      cnt_q;
  logic [P_WIDTH-1:0] acc_q, tacc_q;

  logic [P_WIDTH-1:0] a_ext, a_sh, acc_nxt, tacc_nxt;
  logic               b_bit, bt_bit, neg_step, last;
  int                 a_lsb;

  function automatic int lowest_set(input logic [A_WIDTH-1:0] v);
    int idx;
    idx = 0;
    for (int k = A_WIDTH - 1; k >= 0; k--) begin
      if (v[k]) idx = k;
    end
    return idx;
  endfunction

  always_comb begin
    a_ext    = {{(P_WIDTH - A_WIDTH){sm_q & a_q[A_WIDTH-1]}}, a_q};
    a_sh     = a_ext << cnt_q;
    b_bit    = b_q[cnt_q];
    bt_bit   = bt_q[cnt_q];
    neg_step = sm_q && (cnt_q == CNT_LAST);
    a_lsb    = lowest_set(at_q);

    acc_nxt = acc_q;
    if (b_bit) begin
      acc_nxt = neg_step ? (acc_q - a_sh) : (acc_q + a_sh);
    end

    // Carries only move upward, so taint smears from the lowest affected bit to the MSB.
    tacc_nxt = tacc_q;
    if (bt_bit) begin
      tacc_nxt = tacc_q | (ONES << cnt_q);
    end else if (b_bit && (|at_q)) begin
      tacc_nxt = tacc_q | (ONES << (int'(cnt_q) + a_lsb));
    end

`ifdef SEQ_MULT_EARLY_EXIT_EN
    // Stop once no value or taint bit remains above the current position.
    last = (cnt_q == CNT_LAST) ||
           (!sm_q && (((b_q | bt_q) >> cnt_q) <= B_WIDTH'(1)));
`else
    last = (cnt_q == CNT_LAST);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      at_q      <= '0;
      b_q       <= '0;
      bt_q      <= '0;
      sm_q      <= 1'b0;
      st_q      <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      tacc_q    <= '0;
      product   <= '0;
      product_t <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        a_q    <= multiplicand;
        at_q   <= multiplicand_t;
        b_q    <= multiplier;
        bt_q   <= multiplier_t;
        sm_q   <= signed_mode;
        st_q   <= start_t;
        cnt_q  <= '0;
        acc_q  <= '0;
        tacc_q <= '0;
      end
    end else if (state == S_RUN) begin
      acc_q  <= acc_nxt;
      tacc_q <= tacc_nxt;
      cnt_q  <= cnt_q + 1'b1;
      if (last) begin
        product   <= acc_nxt;
        product_t <= st_q ? ONES : tacc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_taint_gen.sv
// Directed self-checking bench for seq_mult_taint_gen (8x8 defaults).
module tb_seq_mult_taint_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        start_t;
  logic [7:0]  multiplicand_t;
  logic [7:0]  multiplier_t;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [15:0] product_t;

  int errors = 0;
  int checks = 0;

`ifdef SEQ_MULT_EARLY_EXIT_EN
  localparam int EXIT_LAT = 1;
`else
  localparam int EXIT_LAT = 8;
`endif

  seq_mult_taint_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .signed_mode    (signed_mode),
    .multiplicand   (multiplicand),
    .multiplier     (multiplier),
    .start_t        (start_t),
    .multiplicand_t (multiplicand_t),
    .multiplier_t   (multiplier_t),
    .busy           (busy),
    .done           (done),
    .product        (product),
    .product_t      (product_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one start pulse that is sampled at the next rising edge (edge N).
  task automatic start_op(input logic sm, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] at, input logic [7:0] bt, input logic st);
    @(negedge clk);
    start          = 1'b1;
    signed_mode    = sm;
    multiplicand   = a;
    multiplier     = b;
    multiplicand_t = at;
    multiplier_t   = bt;
    start_t        = st;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the current point until done is seen; 0 means timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0 || product_t !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b product=%h product_t=%h, want 0 0 0000 0000",
               busy, done, product, product_t);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_max;
    int cyc;
    start_op(1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL latency_255x255: got %0d want 8", cyc);
    end
    checks++;
    if (product !== 16'hFE01 || product_t !== 16'h0000) begin
      errors++;
      $display("FAIL prod_255x255: got %h/%h want fe01/0000", product, product_t);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_signed;
    logic        sm_v [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0]  a_v  [3] = '{8'hFD, 8'h80, 8'h80};
    logic [7:0]  b_v  [3] = '{8'h05, 8'h80, 8'h80};
    logic [15:0] p_v  [3] = '{16'hFFF1, 16'h4000, 16'h4000};
    int cyc;
    for (int k = 0; k < 3; k++) begin
      start_op(sm_v[k], a_v[k], b_v[k], 8'h00, 8'h00, 1'b0);
      wait_done(cyc);
      checks++;
      if (cyc !== 8 || product !== p_v[k]) begin
        errors++;
        $display("FAIL mode_vec%0d: lat=%0d product=%h want lat=8 product=%h", k, cyc, product, p_v[k]);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_taint;
    logic [7:0]  at_v [3] = '{8'h01, 8'h00, 8'h00};
    logic [7:0]  bt_v [3] = '{8'h00, 8'h80, 8'h00};
    logic        st_v [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] t_v  [3] = '{16'hFFFE, 16'hFF80, 16'hFFFF};
    int cyc;
    for (int k = 0; k < 3; k++) begin
      start_op(1'b0, 8'd3, 8'd2, at_v[k], bt_v[k], st_v[k]);
      wait_done(cyc);
      checks++;
      if (product !== 16'd6 || product_t !== t_v[k]) begin
        errors++;
        $display("FAIL taint_vec%0d: got %h/%h want 0006/%h", k, product, product_t, t_v[k]);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    start_op(1'b0, 8'd15, 8'd15, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 8'd1;
    multiplier   = 8'd2;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc !== 6 || product !== 16'd225) begin
      errors++;
      $display("FAIL ignore_start_in_run: lat=%0d product=%0d want 6 225", cyc, product);
    end
    @(posedge clk);
    start_op(1'b0, 8'd1, 8'd2, 8'h00, 8'h00, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 8 || product !== 16'd2) begin
      errors++;
      $display("FAIL back_to_back: lat=%0d product=%0d want 8 2", cyc, product);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    start_op(1'b0, 8'd92, 8'd75, 8'h0F, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0 || product_t !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b product=%h product_t=%h want 0 0 0000 0000",
               busy, done, product, product_t);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(1'b0, 8'd42, 8'd78, 8'h00, 8'h00, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 8 || product !== 16'd3276 || product_t !== 16'h0) begin
      errors++;
      $display("FAIL restart_after_reset: lat=%0d product=%0d/%h want 8 3276/0000", cyc, product, product_t);
    end
    @(posedge clk);
  endtask

  task automatic test_early_exit;
    int cyc;
    start_op(1'b0, 8'd12, 8'd1, 8'h00, 8'h00, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== EXIT_LAT || product !== 16'd12) begin
      errors++;
      $display("FAIL early_exit_unsigned: lat=%0d product=%0d want %0d 12", cyc, product, EXIT_LAT);
    end
    @(posedge clk);
    start_op(1'b1, 8'd12, 8'd1, 8'h00, 8'h00, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 8 || product !== 16'd12) begin
      errors++;
      $display("FAIL early_exit_signed: lat=%0d product=%0d want 8 12", cyc, product);
    end
    @(posedge clk);
    // Multiplier taint in bit 7 keeps the run going even though B is small.
    start_op(1'b0, 8'd12, 8'd1, 8'h00, 8'h80, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 8 || product !== 16'd12 || product_t !== 16'hFF80) begin
      errors++;
      $display("FAIL exit_blocked_by_taint: lat=%0d product=%0d/%h want 8 12/ff80", cyc, product, product_t);
    end
    @(posedge clk);
  endtask

  initial begin
    start          = 1'b0;
    signed_mode    = 1'b0;
    multiplicand   = 8'h00;
    multiplier     = 8'h00;
    start_t        = 1'b0;
    multiplicand_t = 8'h00;
    multiplier_t   = 8'h00;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_taint();
    test_back_to_back();
    test_reset_mid_run();
    test_early_exit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
